// File: rtl/parking_lot_sensor_fsm.sv
// rtl/parking_lot_sensor_fsm.sv - gate sensor synchronizer, debounce filter and entry/exit sequencer
module parking_lot_sensor_fsm #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic inc,
    output logic dec,
    output logic fault
);

    typedef enum logic [2:0] {
        IDLE,
        EN_A,
        EN_AB,
        EN_B,
        EX_B,
        EX_AB,
        EX_A,
        FAULT
    } state_t;

    localparam logic [7:0] LAST = 8'(FILTER_CYCLES - 1);

    logic [1:0] meta;
    logic [1:0] sync;
    logic [1:0] sync_q;
    logic [1:0] f;
    logic [7:0] cnt;
    state_t     state;

    // Stability filter: sync_q detects a fresh change so the count restarts at one sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 2'b00;
            sync   <= 2'b00;
            sync_q <= 2'b00;
            f      <= 2'b00;
            cnt    <= 8'd0;
        end else begin
            meta   <= {a, b};
            sync   <= meta;
            sync_q <= sync;
            if (sync == f) begin
                cnt <= 8'd0;
            end else if ((sync != sync_q) && (FILTER_CYCLES > 1)) begin
                cnt <= 8'd1;
            end else if (cnt == LAST) begin
                f   <= sync;
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // fault only changes on entering or leaving FAULT, so it holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            inc   <= 1'b0;
            dec   <= 1'b0;
            fault <= 1'b0;
        end else begin
            inc <= 1'b0;
            dec <= 1'b0;
            case (state)
                IDLE: begin
                    if (f == 2'b10) state <= EN_A;
                    else if (f == 2'b01) state <= EX_B;
                    else if (f == 2'b11) begin state <= FAULT; fault <= 1'b1; end
                end
                EN_A: begin
                    if (f == 2'b11) state <= EN_AB;
                    else if (f == 2'b00) state <= IDLE;
                    else if (f == 2'b01) begin state <= FAULT; fault <= 1'b1; end
                end
                EN_AB: begin
                    if (f == 2'b01) state <= EN_B;
                    else if (f == 2'b10) state <= EN_A;
                    else if (f == 2'b00) begin state <= FAULT; fault <= 1'b1; end
                end
                EN_B: begin
                    if (f == 2'b00) begin state <= IDLE; inc <= 1'b1; end
                    else if (f == 2'b11) state <= EN_AB;
                    else if (f == 2'b10) begin state <= FAULT; fault <= 1'b1; end
                end
                EX_B: begin
                    if (f == 2'b11) state <= EX_AB;
                    else if (f == 2'b00) state <= IDLE;
                    else if (f == 2'b10) begin state <= FAULT; fault <= 1'b1; end
                end
                EX_AB: begin
                    if (f == 2'b10) state <= EX_A;
                    else if (f == 2'b01) state <= EX_B;
                    else if (f == 2'b00) begin state <= FAULT; fault <= 1'b1; end
                end
                EX_A: begin
                    if (f == 2'b00) begin state <= IDLE; dec <= 1'b1; end
                    else if (f == 2'b11) state <= EX_AB;
                    else if (f == 2'b01) begin state <= FAULT; fault <= 1'b1; end
                end
                FAULT: begin
                    if (f == 2'b00) begin state <= IDLE; fault <= 1'b0; end
                end
                default: begin
                    state <= IDLE;
                    fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_lot_sensor_fsm.sv
// tb/tb_parking_lot_sensor_fsm.sv - directed scoreboard bench for parking_lot_sensor_fsm
module tb_parking_lot_sensor_fsm;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic a = 1'b0;
    logic b = 1'b0;
    logic inc;
    logic dec;
    logic fault;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Expected pulses: kind 0 = inc, 1 = dec, at an absolute cycle number.
    typedef struct {
        int kind;
        int cycle;
    } pulse_t;
    pulse_t exp_q[$];

    parking_lot_sensor_fsm #(.FILTER_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .inc   (inc),
        .dec   (dec),
        .fault (fault)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (inc === 1'b1 || dec === 1'b1) begin
            pulse_t p;
            chk("inc_dec_exclusive", int'(inc & dec), 0);
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", int'(inc) * 2 + int'(dec), 0);
            end else begin
                p = exp_q.pop_front();
                chk("pulse_kind", dec ? 1 : 0, p.kind);
                chk("pulse_cycle", cyc, p.cycle);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge; the next edge is edge 1 of the latency chain.
    task automatic drive(input logic [1:0] ab, input int exp_kind);
        pulse_t p;
        {a, b} = ab;
        if (exp_kind >= 0) begin
            p.kind = exp_kind;
            p.cycle = cyc + 7;
            exp_q.push_back(p);
        end
    endtask

    task automatic step(input logic [1:0] ab, input int exp_kind);
        drive(ab, exp_kind);
        wait_cycles(12);
    endtask

    initial begin
        wait_cycles(3);
        chk("reset_inc", int'(inc), 0);
        chk("reset_dec", int'(dec), 0);
        chk("reset_fault", int'(fault), 0);
        reset = 1'b0;
        wait_cycles(3);

        // Entry
        step(2'b10, -1); step(2'b11, -1); step(2'b01, -1); step(2'b00, 0);
        chk("entry_fault", int'(fault), 0);
        // Exit
        step(2'b01, -1); step(2'b11, -1); step(2'b10, -1); step(2'b00, 1);
        // Pedestrian and back-out
        step(2'b10, -1); step(2'b00, -1);
        step(2'b10, -1); step(2'b11, -1); step(2'b10, -1); step(2'b00, -1);
        chk("abort_fault", int'(fault), 0);

        // Entry with a 2-cycle glitch on b during 11
        step(2'b10, -1);
        drive(2'b11, -1); wait_cycles(5);
        drive(2'b10, -1); wait_cycles(2);
        drive(2'b11, -1); wait_cycles(10);
        step(2'b01, -1); step(2'b00, 0);

        // Illegal 00 -> 11
        drive(2'b11, -1);
        wait_cycles(6);
        chk("fault_before_latency", int'(fault), 0);
        wait_cycles(1);
        chk("fault_set", int'(fault), 1);
        wait_cycles(5);
        step(2'b01, -1);
        chk("fault_held_01", int'(fault), 1);
        drive(2'b00, -1);
        wait_cycles(6);
        chk("fault_still_set", int'(fault), 1);
        wait_cycles(1);
        chk("fault_cleared", int'(fault), 0);
        wait_cycles(5);
        step(2'b10, -1); step(2'b11, -1); step(2'b01, -1); step(2'b00, 0);

        // Reset while in EN_AB, then 01 -> 00 with no pulse
        step(2'b10, -1); step(2'b11, -1);
        reset = 1'b1;
        wait_cycles(1);
        chk("midreset_inc", int'(inc), 0);
        chk("midreset_dec", int'(dec), 0);
        chk("midreset_fault", int'(fault), 0);
        reset = 1'b0;
        step(2'b01, -1);
        chk("after_reset_fault", int'(fault), 0);
        step(2'b00, -1);
        // Back-to-back entries followed by a full exit
        step(2'b10, -1); step(2'b11, -1); step(2'b01, -1); step(2'b00, 0);
        step(2'b10, -1); step(2'b11, -1); step(2'b01, -1); step(2'b00, 0);
        step(2'b01, -1); step(2'b11, -1); step(2'b10, -1); step(2'b00, 1);

        wait_cycles(10);
        chk("missing_pulses", exp_q.size(), 0);
        chk("final_fault", int'(fault), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
